// File: rtl/zx_pkg.sv
// Shared definitions for the ZX Spectrum keyboard block.
// Holds the PS/2 set-2 prefix codes, the receiver state encoding and the
// scancode-to-matrix lookup.
// The matrix is a flat 40-bit vector: key index = row*5 + col.
// Column 0 is the outermost key of each half-row.
package zx_pkg;

  localparam logic [7:0] PFX_BREAK = 8'hF0;
  localparam logic [7:0] PFX_EXT   = 8'hE0;

  localparam int NROWS = 8;
  localparam int NCOLS = 5;
  localparam int NKEYS = NROWS * NCOLS;

  // Set-2 make code of every matrix position, in key-index order.
  localparam logic [7:0] KEY_CODE [NKEYS] = '{
    8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,   // row0: CapsShift Z X C V
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,   // row1: A S D F G
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,   // row2: Q W E R T
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,   // row3: 1 2 3 4 5
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,   // row4: 0 9 8 7 6
    8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,   // row5: P O I U Y
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,   // row6: Enter L K J H
    8'h29, 8'h14, 8'h3A, 8'h31, 8'h32    // row7: Space SymShift M N B
  };

  localparam int KEY_CAPS = 0;   // row0 col0
  localparam int KEY_ZERO = 20;  // row4 col0
  localparam int KEY_SYM  = 36;  // row7 col1

  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_CTRL   = 8'h14;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Set of matrix keys touched by a scancode. Behind an E0 prefix only
  // right Ctrl maps; everything else extended is ignored.
  function automatic logic [NKEYS-1:0] key_mask(input logic [7:0] code,
                                                input logic       ext);
    logic [NKEYS-1:0] m;
    m = '0;
    if (ext) begin
      if (code == SC_CTRL) m[KEY_SYM] = 1'b1;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (code == KEY_CODE[i]) m[i] = 1'b1;
      end
      if (code == SC_RSHIFT) m[KEY_CAPS] = 1'b1;
      // Backspace is CapsShift+0 on the Spectrum.
      if (code == SC_BKSP) begin
        m[KEY_CAPS] = 1'b1;
        m[KEY_ZERO] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host byte receiver.
// Synchronizes and glitch-filters ps2c/ps2d, strobes on each filtered ps2c
// falling edge, frames start/8 data/odd parity/stop and drops partial
// frames after TIMEOUT clocks of ps2c inactivity.
// Ports:
//   clock, reset : system clock, async active-high reset
//   ps2c, ps2d   : raw PS/2 clock and data (asynchronous)
//   data         : last correctly received byte
//   valid        : one-clock strobe when data is updated
module ps2_rx
  import zx_pkg::*;
#(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 3500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] data,
  output logic       valid
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic c_meta_q, c_sync_q, d_meta_q, d_sync_q;
  logic c_filt_q, c_filt_d, d_filt_q, d_filt_d;
  logic [FW-1:0] c_cnt_q, c_cnt_d, d_cnt_q, d_cnt_d;
  logic [TW-1:0] to_q, to_d;
  rx_state_t state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic par_q, par_d;
  logic valid_q, valid_d;
  logic strobe, rx_bit, timed_out;

  // Input conditioning: the filtered level only moves after FILTER
  // consecutive synchronized samples disagree with it.
  always_comb begin
    c_filt_d = c_filt_q;
    c_cnt_d  = '0;
    if (c_sync_q != c_filt_q) begin
      if (c_cnt_q == FW'(FILTER - 1)) c_filt_d = c_sync_q;
      else                            c_cnt_d  = c_cnt_q + 1'b1;
    end
    d_filt_d = d_filt_q;
    d_cnt_d  = '0;
    if (d_sync_q != d_filt_q) begin
      if (d_cnt_q == FW'(FILTER - 1)) d_filt_d = d_sync_q;
      else                            d_cnt_d  = d_cnt_q + 1'b1;
    end
  end

  assign strobe = c_filt_q & ~c_filt_d;
  assign rx_bit = d_filt_q;

  // Timeout counter restarts on every bit and saturates while idle.
  always_comb begin
    if (strobe)                     to_d = '0;
    else if (to_q == TW'(TIMEOUT))  to_d = to_q;
    else                            to_d = to_q + 1'b1;
  end

  assign timed_out = (state_q != RX_IDLE) && (to_q == TW'(TIMEOUT));

  // Frame FSM.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    par_d    = par_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    if (strobe) begin
      case (state_q)
        RX_IDLE: begin
          if (!rx_bit) begin
            state_d  = RX_DATA;
            bitcnt_d = '0;
          end
        end
        RX_DATA: begin
          sh_d     = {rx_bit, sh_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = rx_bit;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          // Odd parity across data+parity, stop must be high.
          if (rx_bit && (^{sh_q, par_q})) begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (timed_out) begin
      state_d = RX_IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
      c_filt_q <= 1'b1;
      d_filt_q <= 1'b1;
      c_cnt_q  <= '0;
      d_cnt_q  <= '0;
      to_q     <= '0;
      state_q  <= RX_IDLE;
      bitcnt_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      c_meta_q <= ps2c;
      c_sync_q <= c_meta_q;
      d_meta_q <= ps2d;
      d_sync_q <= d_meta_q;
      c_filt_q <= c_filt_d;
      d_filt_q <= d_filt_d;
      c_cnt_q  <= c_cnt_d;
      d_cnt_q  <= d_cnt_d;
      to_q     <= to_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      valid_q  <= valid_d;
    end
  end

  // Datapath registers: only meaningful when qualified by state/valid.
  always_ff @(posedge clock) begin
    sh_q   <= sh_d;
    par_q  <= par_d;
    data_q <= data_d;
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/keyboard.sv
// PS/2 keyboard to ZX Spectrum 48 8x5 key matrix.
// Decodes set-2 make/break/extended sequences into a matrix register and
// answers ULA port-FE reads combinationally.
// Ports:
//   clock, reset : system clock, async active-high reset
//   ps2c, ps2d   : raw PS/2 clock and data
//   row          : a[15:8], a low bit selects that matrix row
//   q            : active-low column bits, bit0 = outermost key
//   pressed      : one-clock pulse per mapped make code
module keyboard
  import zx_pkg::*;
#(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 3500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic [7:0] row,
  output logic [4:0] q,
  output logic       pressed
);

  logic [7:0] rx_data;
  logic       rx_valid;

  ps2_rx #(
    .FILTER (FILTER),
    .TIMEOUT(TIMEOUT)
  ) u_rx (
    .clock(clock),
    .reset(reset),
    .ps2c (ps2c),
    .ps2d (ps2d),
    .data (rx_data),
    .valid(rx_valid)
  );

  logic             rel_q, rel_d, ext_q, ext_d;
  logic [NKEYS-1:0] key_q, key_d, mask;
  logic             pressed_q, pressed_d;
  logic [4:0]       col_or;

  // Decoder: prefixes set flags, any other byte consumes them.
  always_comb begin
    mask      = key_mask(rx_data, ext_q);
    rel_d     = rel_q;
    ext_d     = ext_q;
    key_d     = key_q;
    pressed_d = 1'b0;
    if (rx_valid) begin
      if (rx_data == PFX_BREAK) begin
        rel_d = 1'b1;
      end else if (rx_data == PFX_EXT) begin
        ext_d = 1'b1;
      end else begin
        if (rel_q) begin
          key_d = key_q & ~mask;
        end else begin
          key_d     = key_q | mask;
          pressed_d = |mask;
        end
        rel_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rel_q     <= 1'b0;
      ext_q     <= 1'b0;
      key_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      rel_q     <= rel_d;
      ext_q     <= ext_d;
      key_q     <= key_d;
      pressed_q <= pressed_d;
    end
  end

  // Read path: OR the columns of every selected row, then invert.
  always_comb begin
    col_or = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (!row[r]) col_or = col_or | key_q[r*NCOLS +: NCOLS];
    end
  end

  assign q       = ~col_or;
  assign pressed = pressed_q;

endmodule
